// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with prescaled ticks, per-digit borrow ripple,
// terminal-count done pulse and optional wrap to all-9s.
module bcd_down_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1,
  parameter int WRAP     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  // state | meaning
  // IDLE  | stopped; start launches a countdown (non-zero count, or WRAP=1)
  // RUN   | prescaler advancing, count decrements on each terminal tick
  // PAUSE | count and prescaler frozen until start alone is seen
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;

  logic [CW-1:0] load_clean;
  logic          load_bad;
  logic [CW-1:0] count_dec;

  // Digits above 9 are clamped to 9 so the register only ever holds valid BCD.
  always_comb begin
    load_clean = load_val;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd9;
        load_bad             = 1'b1;
      end
    end
  end

  always_comb begin
    logic borrow;
    count_dec = count_q;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_clean;
      load_err_d = load_bad;
      state_d    = IDLE;
      presc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && ((count_q != '0) || (WRAP != 0))) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_dec;
            if (count_dec == '0) begin
              done_d = 1'b1;
              if (WRAP == 0) state_d = IDLE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start && !pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign running  = (state_q == RUN);
  assign zero     = (count_q == '0);
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: three instances (plain, WRAP=1, TICK_DIV=3)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic        reset, load, start, pause;
  logic [15:0] load_val;

  logic [15:0] c0, c1, c2;
  logic        r0, r1, r2, z0, z1, z2, d0, d1, d2, e0, e1, e2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(4), .TICK_DIV(1), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .count(c0), .running(r0), .zero(z0), .done(d0), .load_err(e0));
  bcd_down_counter #(.DIGITS(4), .TICK_DIV(1), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .count(c1), .running(r1), .zero(z1), .done(d1), .load_err(e1));
  bcd_down_counter #(.DIGITS(4), .TICK_DIV(3), .WRAP(0)) dut2 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .count(c2), .running(r2), .zero(z2), .done(d2), .load_err(e2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 16'h0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (c0 !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", c0); end
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", r0); end
    checks++; if (z0 !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", z0); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", d0); end
    checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", e0); end
  endtask

  task automatic test_countdown();
    logic [15:0] exp_seq [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                  16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    do_load(16'h0012);
    checks++; if (c0 !== 16'h0012) begin errors++; $display("FAIL cd_load got %h exp 0012", c0); end
    checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL cd_load_err got %b exp 0", e0); end
    checks++; if (z0 !== 1'b0) begin errors++; $display("FAIL cd_zero_loaded got %b exp 0", z0); end
    do_start();
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL cd_running_start got %b exp 1", r0); end
    checks++; if (c0 !== 16'h0012) begin errors++; $display("FAIL cd_count_start got %h exp 0012", c0); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (c0 !== exp_seq[i]) begin errors++; $display("FAIL cd_step%0d got %h exp %h", i, c0, exp_seq[i]); end
      checks++; if (d0 !== (i == 11)) begin errors++; $display("FAIL cd_done%0d got %b exp %b", i, d0, (i == 11)); end
      checks++; if (r0 !== (i != 11)) begin errors++; $display("FAIL cd_running%0d got %b exp %b", i, r0, (i != 11)); end
    end
    checks++; if (z0 !== 1'b1) begin errors++; $display("FAIL cd_zero_end got %b exp 1", z0); end
    tick();
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL cd_done_clear got %b exp 0", d0); end
    checks++; if (c0 !== 16'h0000) begin errors++; $display("FAIL cd_hold_zero got %h exp 0000", c0); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL cd_start_at_zero got %b exp 0", r0); end
  endtask

  task automatic test_borrow();
    logic [15:0] ld  [3] = '{16'h1000, 16'h0100, 16'h9000};
    logic [15:0] exv [3] = '{16'h0999, 16'h0099, 16'h8999};
    for (int i = 0; i < 3; i++) begin
      do_load(ld[i]);
      do_start();
      tick();
      checks++; if (c0 !== exv[i]) begin errors++; $display("FAIL borrow%0d got %h exp %h", i, c0, exv[i]); end
    end
    tick();
    checks++; if (c0 !== 16'h8998) begin errors++; $display("FAIL borrow_next got %h exp 8998", c0); end
  endtask

  task automatic test_invalid_load();
    do_load(16'h0A5F);
    checks++; if (c0 !== 16'h0959) begin errors++; $display("FAIL inv_count got %h exp 0959", c0); end
    checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL inv_err got %b exp 1", e0); end
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL inv_running got %b exp 0", r0); end
    tick();
    checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL inv_err_clear got %b exp 0", e0); end
    checks++; if (c0 !== 16'h0959) begin errors++; $display("FAIL inv_hold got %h exp 0959", c0); end
  endtask

  task automatic test_pause();
    do_load(16'h0005);
    pause = 1'b1; tick(); pause = 1'b0;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL pause_idle got %b exp 0", r0); end
    do_start();
    tick(); tick();
    checks++; if (c0 !== 16'h0003) begin errors++; $display("FAIL pause_pre got %h exp 0003", c0); end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      tick();
      checks++; if (c0 !== 16'h0003) begin errors++; $display("FAIL pause_hold%0d got %h exp 0003", i, c0); end
      checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL pause_run%0d got %b exp 0", i, r0); end
    end
    pause = 1'b0;
    do_start();
    checks++; if (r0 !== 1'b1 || c0 !== 16'h0003) begin errors++; $display("FAIL pause_resume got %b/%h exp 1/0003", r0, c0); end
    tick();
    checks++; if (c0 !== 16'h0002) begin errors++; $display("FAIL resume1 got %h exp 0002", c0); end
    tick();
    checks++; if (c0 !== 16'h0001) begin errors++; $display("FAIL resume2 got %h exp 0001", c0); end
    tick();
    checks++; if (c0 !== 16'h0000 || d0 !== 1'b1) begin errors++; $display("FAIL resume_done got %h/%b exp 0000/1", c0, d0); end
  endtask

  task automatic test_wrap();
    do_load(16'h0001);
    do_start();
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL wrap_start got %b exp 1", r1); end
    tick();
    checks++; if (c1 !== 16'h0000 || d1 !== 1'b1) begin errors++; $display("FAIL wrap_zero got %h/%b exp 0000/1", c1, d1); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL wrap_run0 got %b exp 1", r1); end
    tick();
    checks++; if (c1 !== 16'h9999 || d1 !== 1'b0) begin errors++; $display("FAIL wrap_9999 got %h/%b exp 9999/0", c1, d1); end
    tick();
    checks++; if (c1 !== 16'h9998 || r1 !== 1'b1) begin errors++; $display("FAIL wrap_9998 got %h/%b exp 9998/1", c1, r1); end
    do_load(16'h0000);
    do_start();
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL wrap_start_zero got %b exp 1", r1); end
    tick();
    checks++; if (c1 !== 16'h9999 || d1 !== 1'b0) begin errors++; $display("FAIL wrap_from_zero got %h/%b exp 9999/0", c1, d1); end
  endtask

  task automatic test_tick_div();
    logic [15:0] exp_seq [9] = '{16'h0003, 16'h0003, 16'h0002, 16'h0002, 16'h0002,
                                 16'h0001, 16'h0001, 16'h0001, 16'h0000};
    do_load(16'h0003);
    do_start();
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (c2 !== exp_seq[i]) begin errors++; $display("FAIL td_step%0d got %h exp %h", i, c2, exp_seq[i]); end
      checks++; if (d2 !== (i == 8)) begin errors++; $display("FAIL td_done%0d got %b exp %b", i, d2, (i == 8)); end
    end
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL td_idle got %b exp 0", r2); end
    do_load(16'h0003);
    do_start();
    tick(); tick(); tick();
    checks++; if (c2 !== 16'h0002 || r2 !== 1'b1) begin errors++; $display("FAIL td_k3 got %h/%b exp 0002/1", c2, r2); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (c2 !== 16'h0000) begin errors++; $display("FAIL td_rst_count got %h exp 0000", c2); end
    checks++; if (r2 !== 1'b0 || d2 !== 1'b0 || z2 !== 1'b1) begin errors++; $display("FAIL td_rst_flags got r%b d%b z%b exp r0 d0 z1", r2, d2, z2); end
    tick();
    checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL td_rst_nodone got %b exp 0", d2); end
    do_start();
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL td_start_zero got %b exp 0", r2); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_invalid_load();
    test_pause();
    test_wrap();
    test_tick_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
